// File: rtl/oq_rr_remove_scheduler_pkg.sv
// Shared definitions for the output-queue remove scheduler: index-width helper
// and FSM state encodings.
package oq_rr_remove_scheduler_pkg;

  // Ceiling log2 with a floor of 1, so a queue index is never zero bits wide
  function automatic int unsigned oq_log2(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w = w + 1;
    return w;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/oq_rr_remove_scheduler_rr_prio_picker.sv
// Round-robin priority picker: first set bit of eligible starting at rr_ptr,
// wrapping N-1 -> 0. Purely combinational; rr_ptr must be < N.
module oq_rr_remove_scheduler_rr_prio_picker #(
  parameter int unsigned N = 8,
  parameter int unsigned W = 3
) (
  input  logic [N-1:0] eligible,
  input  logic [W-1:0] rr_ptr,
  output logic         valid_c,
  output logic [W-1:0] index_c
);

  logic [N-1:0] rotated;
  logic [W:0]   offset;
  logic [W:0]   sum;

  // Bit k of rotated is eligible[(rr_ptr + k) mod N]
  assign rotated = N'({eligible, eligible} >> rr_ptr);

  always_comb begin
    valid_c = 1'b0;
    offset  = '0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      if (rotated[k]) begin
        valid_c = 1'b1;
        offset  = (W+1)'(k);
      end
    end
  end

  assign sum     = {1'b0, rr_ptr} + offset;
  assign index_c = (sum >= (W+1)'(N)) ? W'(sum - (W+1)'(N)) : W'(sum);

endmodule

// File: rtl/oq_rr_remove_scheduler.sv
// Round-robin scheduler choosing which SRAM output queue the read engine drains
// next; tracks per-queue packet counts from store/remove strobes.
module oq_rr_remove_scheduler
  import oq_rr_remove_scheduler_pkg::*;
#(
  parameter int unsigned NUM_OUTPUT_QUEUES = 8,
  parameter int unsigned NUM_OQ_WIDTH      = oq_log2(NUM_OUTPUT_QUEUES),
  parameter int unsigned PKT_CNT_WIDTH     = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         pkt_stored,
  input  logic [NUM_OQ_WIDTH-1:0]      dst_oq,
  input  logic                         pkt_removed,
  input  logic [NUM_OQ_WIDTH-1:0]      removed_oq,
  input  logic [NUM_OUTPUT_QUEUES-1:0] oq_enable,
  input  logic [NUM_OUTPUT_QUEUES-1:0] dst_rdy,
  output logic                         rd_req,
  output logic [NUM_OQ_WIDTH-1:0]      rd_oq,
  input  logic                         rd_ack,
  output logic                         busy,
  output logic [NUM_OUTPUT_QUEUES-1:0] oq_nonempty,
  output logic                         sched_err
);

  localparam int unsigned N  = NUM_OUTPUT_QUEUES;
  localparam int unsigned W  = NUM_OQ_WIDTH;
  localparam int unsigned CW = PKT_CNT_WIDTH;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q [N];
  logic [CW-1:0] count_d [N];
  logic [N-1:0]  nonempty_d;
  logic [N-1:0]  eligible;
  logic [W-1:0]  rr_ptr_q, rr_ptr_d, rd_oq_d;
  logic          rd_req_d, busy_d, err_d;
  logic          cnt_err, done, stray_remove;
  logic          pick_valid;
  logic [W-1:0]  pick_index;

  // Per-queue counters; a store and remove on the same queue cancel out
  always_comb begin
    cnt_err = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      count_d[i] = count_q[i];
      if (pkt_stored && dst_oq == W'(i) && !(pkt_removed && removed_oq == W'(i))) begin
        if (&count_q[i]) cnt_err = 1'b1;
        else             count_d[i] = count_q[i] + CW'(1);
      end else if (pkt_removed && removed_oq == W'(i) && !(pkt_stored && dst_oq == W'(i))) begin
        if (count_q[i] == '0) cnt_err = 1'b1;
        else                  count_d[i] = count_q[i] - CW'(1);
      end
      nonempty_d[i] = (count_d[i] != '0);
    end
  end

  assign eligible = oq_nonempty & oq_enable & dst_rdy;

  oq_rr_remove_scheduler_rr_prio_picker #(
    .N (N),
    .W (W)
  ) u_picker (
    .eligible (eligible),
    .rr_ptr   (rr_ptr_q),
    .valid_c  (pick_valid),
    .index_c  (pick_index)
  );

  // Only a removal of the granted queue while waiting completes a grant
  assign done         = (state_q == ST_WAIT) && pkt_removed && (removed_oq == rd_oq);
  assign stray_remove = pkt_removed && !done;
  assign err_d        = sched_err | cnt_err | stray_remove;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (pick_valid) state_d = ST_REQ;
      ST_REQ:  if (rd_ack)     state_d = ST_WAIT;
      ST_WAIT: if (done)       state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_oq_d  = rd_oq;
    rr_ptr_d = rr_ptr_q;
    rd_req_d = (state_d == ST_REQ);
    busy_d   = (state_d != ST_IDLE);
    if (state_q == ST_IDLE && pick_valid) rd_oq_d = pick_index;
    if (done) rr_ptr_d = (rd_oq == W'(N - 1)) ? '0 : rd_oq + W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(N); i++) count_q[i] <= '0;
      oq_nonempty <= '0;
      rr_ptr_q    <= '0;
      rd_oq       <= '0;
      rd_req      <= 1'b0;
      busy        <= 1'b0;
      sched_err   <= 1'b0;
    end else begin
      for (int i = 0; i < int'(N); i++) count_q[i] <= count_d[i];
      oq_nonempty <= nonempty_d;
      rr_ptr_q    <= rr_ptr_d;
      rd_oq       <= rd_oq_d;
      rd_req      <= rd_req_d;
      busy        <= busy_d;
      sched_err   <= err_d;
    end
  end

endmodule

// File: tb/tb_oq_rr_remove_scheduler.sv
// Self-checking bench for oq_rr_remove_scheduler: table of load/mask vectors with
// expected grant order on a scoreboard queue, plus hand-written corner sequences.
module tb_oq_rr_remove_scheduler;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       pkt_stored, pkt_removed, rd_ack;
  logic [2:0] dst_oq, removed_oq;
  logic [7:0] oq_enable, dst_rdy;
  logic       rd_req, busy, sched_err;
  logic [2:0] rd_oq;
  logic [7:0] oq_nonempty;

  int checks   = 0;
  int failures = 0;
  int exp_q[$];

  typedef struct packed {
    logic [7:0]       en;
    logic [7:0]       rdy;
    logic [7:0][1:0]  load;
    logic [7:0]       fin;
    logic [4:0]       n;
    logic [15:0][2:0] order;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];

  oq_rr_remove_scheduler dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .pkt_stored  (pkt_stored),
    .dst_oq      (dst_oq),
    .pkt_removed (pkt_removed),
    .removed_oq  (removed_oq),
    .oq_enable   (oq_enable),
    .dst_rdy     (dst_rdy),
    .rd_req      (rd_req),
    .rd_oq       (rd_oq),
    .rd_ack      (rd_ack),
    .busy        (busy),
    .oq_nonempty (oq_nonempty),
    .sched_err   (sched_err)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0; pkt_stored = 1'b0; pkt_removed = 1'b0; rd_ack = 1'b0;
    dst_oq = '0; removed_oq = '0; oq_enable = 8'hff; dst_rdy = '0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic store(input logic [2:0] q);
    pkt_stored = 1'b1; dst_oq = q;
    @(negedge clk);
    pkt_stored = 1'b0;
  endtask

  task automatic wait_req(input int budget);
    for (int c = 0; c < budget && !rd_req; c++) @(negedge clk);
    check("wait_req", 32'(rd_req), 32'd1);
  endtask

  // Read engine: ack each request at once, then remove the granted queue
  task automatic serve(input int budget);
    logic [2:0] q;
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (rd_req) begin
        q = rd_oq;
        check("grant_oq", 32'(q), 32'(exp_q.pop_front()));
        rd_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
        check("req_drop_after_ack", 32'(rd_req), 32'd0);
        check("busy_in_wait", 32'(busy), 32'd1);
        pkt_removed = 1'b1; removed_oq = q;
        @(negedge clk);
        pkt_removed = 1'b0;
        check("busy_after_done", 32'(busy), 32'd0);
        check("idle_gap", 32'(rd_req), 32'd0);
      end
    end
    check("serve_pending", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic quiet(input int n, output int hits);
    hits = 0;
    repeat (n) begin
      @(negedge clk);
      if (rd_req || busy) hits++;
    end
  endtask

  initial begin
    int hits;

    for (int v = 0; v < NV; v++) begin
      vecs[v] = '0;
      vecs[v].en  = 8'hff;
      vecs[v].rdy = 8'hff;
    end
    vecs[0].load[3] = 2'd1; vecs[0].n = 5'd1; vecs[0].order[0] = 3'd3;
    for (int q = 0; q < 8; q++) vecs[1].load[q] = 2'd2;
    vecs[1].n = 5'd16;
    for (int k = 0; k < 16; k++) vecs[1].order[k] = 3'(k % 8);
    vecs[2].load[2] = 2'd1; vecs[2].load[5] = 2'd1; vecs[2].rdy = 8'hfb;
    vecs[2].n = 5'd1; vecs[2].order[0] = 3'd5; vecs[2].fin = 8'h04;
    vecs[3].load[1] = 2'd1; vecs[3].load[6] = 2'd3; vecs[3].en = 8'hfd;
    vecs[3].n = 5'd3; vecs[3].order[0] = 3'd6; vecs[3].order[1] = 3'd6;
    vecs[3].order[2] = 3'd6; vecs[3].fin = 8'h02;
    vecs[4].load[0] = 2'd1; vecs[4].load[4] = 2'd1; vecs[4].load[7] = 2'd1;
    vecs[4].n = 5'd3; vecs[4].order[0] = 3'd0; vecs[4].order[1] = 3'd4; vecs[4].order[2] = 3'd7;
    vecs[5].load[7] = 2'd2; vecs[5].load[0] = 2'd1;
    vecs[5].n = 5'd3; vecs[5].order[0] = 3'd0; vecs[5].order[1] = 3'd7; vecs[5].order[2] = 3'd7;
    vecs[6].load[6] = 2'd1; vecs[6].load[1] = 2'd1; vecs[6].load[3] = 2'd2; vecs[6].rdy = 8'h4a;
    vecs[6].n = 5'd4; vecs[6].order[0] = 3'd1; vecs[6].order[1] = 3'd3;
    vecs[6].order[2] = 3'd6; vecs[6].order[3] = 3'd3;

    // Reset values and 100 idle cycles
    do_reset();
    check("rst_rd_req", 32'(rd_req), 32'd0);
    check("rst_rd_oq", 32'(rd_oq), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_nonempty", 32'(oq_nonempty), 32'd0);
    check("rst_err", 32'(sched_err), 32'd0);
    dst_rdy = 8'hff;
    quiet(100, hits);
    check("idle_100", 32'(hits), 32'd0);
    check("idle_100_err", 32'(sched_err), 32'd0);

    // Table-driven vectors, each from a fresh reset
    for (int v = 0; v < NV; v++) begin
      do_reset();
      oq_enable = vecs[v].en;
      for (int q = 0; q < 8; q++)
        for (int c = 0; c < int'(vecs[v].load[q]); c++) store(3'(q));
      for (int k = 0; k < int'(vecs[v].n); k++) exp_q.push_back(int'(vecs[v].order[k]));
      dst_rdy = vecs[v].rdy;
      serve(400);
      quiet(20, hits);
      check($sformatf("vec%0d_no_extra", v), 32'(hits), 32'd0);
      check($sformatf("vec%0d_nonempty", v), 32'(oq_nonempty), 32'(vecs[v].fin));
      check($sformatf("vec%0d_err", v), 32'(sched_err), 32'd0);
    end

    // Latency, request hold and rr_ptr advance past the served queue
    do_reset();
    dst_rdy = 8'hff;
    store(3'd3);
    check("lat_t1_no_req", 32'(rd_req), 32'd0);
    check("lat_t1_nonempty", 32'(oq_nonempty), 32'h08);
    @(negedge clk);
    check("lat_t2_req", 32'(rd_req), 32'd1);
    check("lat_t2_oq", 32'(rd_oq), 32'd3);
    check("lat_t2_busy", 32'(busy), 32'd1);
    dst_rdy = 8'h00; oq_enable = 8'h00;
    repeat (3) @(negedge clk);
    check("req_hold", 32'(rd_req), 32'd1);
    check("req_hold_oq", 32'(rd_oq), 32'd3);
    oq_enable = 8'hff;
    rd_ack = 1'b1;
    @(negedge clk);
    rd_ack = 1'b0;
    pkt_removed = 1'b1; removed_oq = 3'd3;
    @(negedge clk);
    pkt_removed = 1'b0;
    check("q3_done_busy", 32'(busy), 32'd0);
    check("q3_done_nonempty", 32'(oq_nonempty), 32'd0);
    store(3'd2);
    store(3'd5);
    dst_rdy = 8'hfb;
    exp_q.push_back(5);
    serve(100);
    dst_rdy = 8'hff;
    exp_q.push_back(2);
    serve(100);
    check("ptr_seq_nonempty", 32'(oq_nonempty), 32'd0);
    check("ptr_seq_err", 32'(sched_err), 32'd0);

    // Same-cycle store+remove, stray ack, remove from empty queue
    do_reset();
    dst_rdy = 8'hff;
    store(3'd1);
    wait_req(10);
    check("same_oq", 32'(rd_oq), 32'd1);
    rd_ack = 1'b1;
    @(negedge clk);
    rd_ack = 1'b0;
    pkt_stored = 1'b1; dst_oq = 3'd1; pkt_removed = 1'b1; removed_oq = 3'd1;
    @(negedge clk);
    pkt_stored = 1'b0; pkt_removed = 1'b0;
    check("same_cycle_busy", 32'(busy), 32'd0);
    check("same_cycle_count", 32'(oq_nonempty), 32'h02);
    check("same_cycle_err", 32'(sched_err), 32'd0);
    exp_q.push_back(1);
    serve(50);
    check("same_cycle_drained", 32'(oq_nonempty), 32'd0);
    rd_ack = 1'b1;
    @(negedge clk);
    rd_ack = 1'b0;
    @(negedge clk);
    check("ack_idle_req", 32'(rd_req), 32'd0);
    check("ack_idle_busy", 32'(busy), 32'd0);
    check("ack_idle_err", 32'(sched_err), 32'd0);
    pkt_removed = 1'b1; removed_oq = 3'd4;
    @(negedge clk);
    pkt_removed = 1'b0;
    check("underflow_err", 32'(sched_err), 32'd1);
    check("underflow_count", 32'(oq_nonempty), 32'd0);
    repeat (5) @(negedge clk);
    check("err_sticky", 32'(sched_err), 32'd1);
    quiet(10, hits);
    check("underflow_no_grant", 32'(hits), 32'd0);

    // Asynchronous reset in the middle of a grant
    do_reset();
    dst_rdy = 8'hff;
    store(3'd0);
    wait_req(10);
    rd_ack = 1'b1;
    @(negedge clk);
    rd_ack = 1'b0;
    check("wait_busy", 32'(busy), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("async_rd_req", 32'(rd_req), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    check("async_nonempty", 32'(oq_nonempty), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    quiet(20, hits);
    check("post_reset_no_grant", 32'(hits), 32'd0);
    check("post_reset_nonempty", 32'(oq_nonempty), 32'd0);
    check("post_reset_err", 32'(sched_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
